// File: rtl/pio_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pio_pattern_sequencer
//
// Purpose: Avalon-MM pattern player for a DATA_W-bit output PIO. Software
// loads a pattern table, a step period and a length through the slave port,
// then sets RUN. The block then masters the PIO data register (offset 0).
// It writes one table entry per period, either once or looping.
//
// Optional feature macro: PIO_SEQ_IRQ_EN
//   defined   -> CTRL.IRQ_EN (bit2) is implemented and
//                done_irq = registered (DONE & IRQ_EN).
//   undefined -> done_irq is tied 0, CTRL bit2 reads 0 and ignores writes.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   s_address[3:0]      slave word address: 0 CTRL, 1 PERIOD, 2 LENGTH,
//                       3 STATUS, 8..8+DEPTH-1 pattern table
//   s_chipselect        slave select
//   s_write_n           slave write strobe, active low
//   s_writedata[31:0]   slave write data
//   s_readdata[31:0]    slave read data, combinational, zero wait states
//   m_address[1:0]      PIO address, always 0
//   m_chipselect        PIO chipselect
//   m_write_n           PIO write strobe, active low
//   m_writedata[31:0]   PIO write data, zero-extended table entry
//   done_irq            sequence-complete interrupt, level
// ---------------------------------------------------------------------------
module pio_pattern_sequencer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 2,
  parameter int CNT_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        done_irq
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Registers
  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run;
  logic               r_loop;
  logic               r_done;
  logic [CNT_W-1:0]   r_period;
  logic [LEN_W-1:0]   r_length;
  logic [DATA_W-1:0]  r_table [DEPTH];

  // Combinational signals
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_run_nxt;
  logic               w_done_nxt;
  logic               w_done_set;
  logic               w_wr;
  logic               w_wr_ctrl;
  logic               w_wr_status;
  logic [3:0]         w_tbl_off;
  logic               w_tbl_hit;
  logic [IDX_W-1:0]   w_tbl_idx;
  logic [LEN_W-1:0]   w_len_eff;
  logic [LEN_W-1:0]   w_idx_inc;
  logic               w_more;
  logic [CNT_W-1:0]   w_per_eff;
  logic               w_busy;
  logic               w_irq_en;
  logic               w_is_write;
  logic [31:0]        w_rdata;
  logic               w_unused_bits;

  // Slave write decode
  assign w_wr        = s_chipselect & ~s_write_n;
  assign w_wr_ctrl   = w_wr & (s_address == 4'd0);
  assign w_wr_status = w_wr & (s_address == 4'd3);

  // Table window starts at word 8; DEPTH is a power of two no larger than the
  // window, so the low offset bits select the entry directly.
  assign w_tbl_off = s_address - 4'd8;
  assign w_tbl_hit = s_address[3] && ({1'b0, w_tbl_off} < 5'(DEPTH));
  assign w_tbl_idx = w_tbl_off[IDX_W-1:0];

  // Effective length clipped to the table size, effective period at least 1
  assign w_len_eff = (r_length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : r_length;
  assign w_per_eff = (r_period == '0) ? CNT_W'(1) : r_period;
  // idx+1 < L rather than idx < L-1 so a LENGTH of 0 written mid-run cannot
  // underflow.
  assign w_idx_inc = LEN_W'(r_idx) + LEN_W'(1);
  assign w_more    = (w_idx_inc < w_len_eff);

  assign w_busy     = (r_state != ST_IDLE);
  assign w_is_write = (r_state == ST_WRITE);

  // Upper write-data bits and unused offset bits are intentionally ignored
  assign w_unused_bits = ^{s_writedata, w_tbl_off};

  // Configuration registers and pattern table, writable at any time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= '0;
      r_length <= '0;
      r_loop   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      if (w_wr && (s_address == 4'd1)) begin
        r_period <= s_writedata[CNT_W-1:0];
      end
      if (w_wr && (s_address == 4'd2)) begin
        r_length <= s_writedata[LEN_W-1:0];
      end
      if (w_wr_ctrl) begin
        r_loop <= s_writedata[1];
      end
      if (w_wr && w_tbl_hit) begin
        r_table[w_tbl_idx] <= s_writedata[DATA_W-1:0];
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_run   <= w_run_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Sequencer next-state logic; a CTRL write overrides the FSM's own step
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_run_nxt   = r_run;
    w_done_set  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = w_per_eff - CNT_W'(1);
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_more) begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_state_nxt = ST_WRITE;
        end else if (r_loop) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = 1'b0;
          w_done_set  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A CTRL write wins over a same-cycle expiry: start/restart or abort
    if (w_wr_ctrl) begin
      w_done_set = 1'b0;
      if (s_writedata[0] && (w_len_eff != '0)) begin
        w_run_nxt   = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = ST_WRITE;
      end else begin
        w_run_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    end else begin
      w_run_nxt = w_run_nxt;
    end

    // DONE is sticky; a completion in the same cycle as a clear is kept
    if (w_done_set) begin
      w_done_nxt = 1'b1;
    end else if (w_wr_status && s_writedata[1]) begin
      w_done_nxt = 1'b0;
    end else begin
      w_done_nxt = r_done;
    end
  end

`ifdef PIO_SEQ_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // IRQ enable bit and registered interrupt level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_irq_en <= s_writedata[2];
      end
      r_irq <= r_done & r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign done_irq = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign done_irq = 1'b0;
`endif

  // Slave read mux, combinational from the address
  always_comb begin
    w_rdata = 32'd0;
    case (s_address)
      4'd0:    w_rdata = {29'd0, w_irq_en, r_loop, r_run};
      4'd1:    w_rdata = 32'(r_period);
      4'd2:    w_rdata = 32'(r_length);
      4'd3:    w_rdata = {20'd0, 4'(r_idx), 6'd0, r_done, w_busy};
      default: begin
        if (w_tbl_hit) begin
          w_rdata = 32'(r_table[w_tbl_idx]);
        end else begin
          w_rdata = 32'd0;
        end
      end
    endcase
  end

  assign s_readdata = w_rdata;

  // Master outputs decode directly from the state register so they drop
  // immediately on async reset.
  assign m_address    = 2'd0;
  assign m_chipselect = w_is_write;
  assign m_write_n    = ~w_is_write;
  assign m_writedata  = w_is_write ? 32'(r_table[r_idx]) : 32'd0;

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pio_pattern_sequencer
//
// Self-checking bench: a table of register access vectors followed by
// hand-written sequences for one-shot, loop/abort, PERIOD=0, LENGTH=0,
// LENGTH>DEPTH, restart-on-expiry, IRQ and async reset during WRITE.
// ---------------------------------------------------------------------------
module tb_pio_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  s_address = 4'd3;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        done_irq;

  pio_pattern_sequencer #(.DEPTH(8), .DATA_W(2), .CNT_W(24)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .done_irq     (done_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_t   = 0;
  int irq_hi   = 0;
  int addr_bad = 0;
  int wq_d[$];
  int wq_c[$];
  logic [31:0] st;
  int ed[16];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        do_wr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic [3:0] a, logic [31:0] d, logic w,
                              logic [31:0] e, string n);
    vec_t v;
    v.addr = a; v.wdata = d; v.do_wr = w; v.exp = e; v.name = n;
    return v;
  endfunction

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // PIO write capture, sampled mid-cycle
  always @(negedge clk) begin
    if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
      wq_d.push_back(int'(m_writedata));
      wq_c.push_back(cyc);
      if (m_address !== 2'd0) addr_bad = addr_bad + 1;
    end
    if (done_irq === 1'b1) irq_hi = irq_hi + 1;
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle slave write, called just after a rising edge
  task automatic wr(logic [3:0] a, logic [31:0] d);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    last_t = cyc;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0; s_write_n = 1'b1; s_address = 4'd3; s_writedata = 32'd0;
  endtask

  task automatic rd(logic [3:0] a, output logic [31:0] d);
    s_address = a;
    #1;
    d = s_readdata;
    s_address = 4'd3;
  endtask

  task automatic wait_idle(string nm, int budget);
    logic [31:0] s;
    s = 32'd1;
    for (int i = 0; i < budget; i++) begin
      step(1);
      rd(4'd3, s);
      if (s[0] == 1'b0) break;
    end
    check({nm, "_idle"}, {31'd0, s[0]}, 32'd0);
  endtask

  task automatic check_stream(string nm, int base, int t0, int sp, int n);
    check({nm, "_count"}, wq_d.size() - base, n);
    for (int k = 0; k < n && (base + k) < wq_d.size(); k++) begin
      check($sformatf("%s_data%0d", nm, k), wq_d[base + k], ed[k]);
      check($sformatf("%s_cyc%0d", nm, k), wq_c[base + k], t0 + 1 + k * sp);
    end
  endtask

  task automatic set_ed(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
    for (int i = 0; i < 16; i++) ed[i] = 0;
    ed[0] = a0; ed[1] = a1; ed[2] = a2; ed[3] = a3;
    ed[4] = a4; ed[5] = a5; ed[6] = a6; ed[7] = a7;
  endtask

  initial begin
    int base;
    int t0;
    int irq0;

    vecs[0]  = mk(4'd3,  32'd0,          1'b0, 32'd0,          "status_rst");
    vecs[1]  = mk(4'd0,  32'd0,          1'b0, 32'd0,          "ctrl_rst");
    vecs[2]  = mk(4'd1,  32'h0012_3456,  1'b1, 32'h0012_3456,  "period_wr");
    vecs[3]  = mk(4'd1,  32'hFFFF_FFFF,  1'b1, 32'h00FF_FFFF,  "period_mask");
    vecs[4]  = mk(4'd2,  32'h0000_000C,  1'b1, 32'h0000_000C,  "length_wr");
    vecs[5]  = mk(4'd8,  32'h0000_0007,  1'b1, 32'h0000_0003,  "tbl0_mask");
    vecs[6]  = mk(4'd15, 32'h0000_0002,  1'b1, 32'h0000_0002,  "tbl7_wr");
    vecs[7]  = mk(4'd4,  32'h0000_FFFF,  1'b1, 32'd0,          "unmapped4");
    vecs[8]  = mk(4'd7,  32'h0000_0001,  1'b1, 32'd0,          "unmapped7");
`ifdef PIO_SEQ_IRQ_EN
    vecs[9]  = mk(4'd0,  32'h0000_0004,  1'b1, 32'h0000_0004,  "ctrl_irqen");
`else
    vecs[9]  = mk(4'd0,  32'h0000_0004,  1'b1, 32'd0,          "ctrl_irqen");
`endif
    vecs[10] = mk(4'd0,  32'h0000_0002,  1'b1, 32'h0000_0002,  "ctrl_loop");
    vecs[11] = mk(4'd0,  32'h0000_0000,  1'b1, 32'd0,          "ctrl_clr");
    vecs[12] = mk(4'd9,  32'd0,          1'b0, 32'd0,          "tbl1_rst");

    // Reset state while reset is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs",    {31'd0, m_chipselect}, 32'd0);
    check("rst_wr_n",  {31'd0, m_write_n},    32'd1);
    check("rst_wdata", m_writedata,           32'd0);
    check("rst_addr",  {30'd0, m_address},    32'd0);
    check("rst_irq",   {31'd0, done_irq},     32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);

    // Register access vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, st);
      check(vecs[i].name, st, vecs[i].exp);
      step(1);
    end

    // One-shot: table {1,2,3}, LENGTH=3, PERIOD=4
    wr(4'd1, 32'd4); wr(4'd2, 32'd3);
    wr(4'd8, 32'd1); wr(4'd9, 32'd2); wr(4'd10, 32'd3);
    base = wq_d.size(); irq0 = irq_hi;
    wr(4'd0, 32'd1); t0 = last_t;
    wait_idle("oneshot", 40);
    set_ed(1, 2, 3, 0, 0, 0, 0, 0);
    check_stream("oneshot", base, t0, 5, 3);
    rd(4'd3, st); check("oneshot_status", st, 32'h0000_0202);
    rd(4'd0, st); check("oneshot_ctrl", st, 32'd0);
`ifndef PIO_SEQ_IRQ_EN
    check("irq_tied_off", irq_hi - irq0, 32'd0);
`endif
    step(1);
    wr(4'd3, 32'd2);
    rd(4'd3, st); check("done_clear", st, 32'h0000_0200);
    step(1);

`ifdef PIO_SEQ_IRQ_EN
    // IRQ: one-shot with IRQ_EN, then clear DONE
    begin
      int done_c;
      int irq_c;
      done_c = -1; irq_c = -1;
      wr(4'd0, 32'd5);
      for (int i = 0; i < 40 && irq_c < 0; i++) begin
        step(1);
        rd(4'd3, st);
        if (st[1] && done_c < 0) done_c = cyc;
        if (done_irq && irq_c < 0) irq_c = cyc;
      end
      check("irq_latency", irq_c - done_c, 32'd1);
      step(1);
      wr(4'd3, 32'd2);
      check("irq_hold", {31'd0, done_irq}, 32'd1);
      step(1);
      check("irq_clear", {31'd0, done_irq}, 32'd0);
      wr(4'd0, 32'd0);
      step(1);
    end
`endif

    // Loop then abort mid-WAIT after the fifth write
    base = wq_d.size();
    wr(4'd0, 32'd3); t0 = last_t;
    step(21);
    wr(4'd0, 32'd0);
    step(15);
    set_ed(1, 2, 3, 1, 2, 0, 0, 0);
    check_stream("loop", base, t0, 5, 5);
    rd(4'd3, st); check("loop_abort_status", {30'd0, st[1:0]}, 32'd0);
    step(1);

    // PERIOD=0 -> writes every 2 cycles
    wr(4'd1, 32'd0);
    base = wq_d.size();
    wr(4'd0, 32'd1); t0 = last_t;
    wait_idle("per0", 20);
    set_ed(1, 2, 3, 0, 0, 0, 0, 0);
    check_stream("per0", base, t0, 2, 3);
    step(1);
    wr(4'd3, 32'd2);

    // LENGTH=0 -> no write, RUN reads 0
    wr(4'd2, 32'd0);
    base = wq_d.size();
    wr(4'd0, 32'd1);
    step(10);
    check("len0_count", wq_d.size() - base, 32'd0);
    rd(4'd0, st); check("len0_ctrl", st, 32'd0);
    rd(4'd3, st); check("len0_status", {30'd0, st[1:0]}, 32'd0);
    step(1);

    // LENGTH=12 with DEPTH=8 -> 8 writes
    wr(4'd2, 32'd12);
    wr(4'd8, 32'd0);  wr(4'd9, 32'd1);  wr(4'd10, 32'd2); wr(4'd11, 32'd3);
    wr(4'd12, 32'd3); wr(4'd13, 32'd2); wr(4'd14, 32'd1); wr(4'd15, 32'd0);
    base = wq_d.size();
    wr(4'd0, 32'd1); t0 = last_t;
    wait_idle("len12", 40);
    set_ed(0, 1, 2, 3, 3, 2, 1, 0);
    check_stream("len12", base, t0, 2, 8);
    rd(4'd3, st); check("len12_status", st, 32'h0000_0702);
    step(1);
    wr(4'd3, 32'd2);

    // Restart on the final-expiry cycle
    wr(4'd1, 32'd4); wr(4'd2, 32'd3);
    wr(4'd8, 32'd1); wr(4'd9, 32'd2); wr(4'd10, 32'd3);
    base = wq_d.size();
    wr(4'd0, 32'd1); t0 = last_t;
    step(14);
    wr(4'd0, 32'd1);
    check("restart_cs", {31'd0, m_chipselect}, 32'd1);
    check("restart_wdata", m_writedata, 32'd1);
    rd(4'd3, st); check("restart_done", {31'd0, st[1]}, 32'd0);
    wr(4'd0, 32'd0);
    step(10);
    set_ed(1, 2, 3, 1, 0, 0, 0, 0);
    check_stream("restart", base, t0, 5, 4);
    rd(4'd3, st); check("restart_status", {30'd0, st[1:0]}, 32'd0);
    check("m_address_const", addr_bad, 32'd0);
    step(1);

    // Async reset asserted during a WRITE cycle
    wr(4'd0, 32'd1);
    check("arst_pre_cs", {31'd0, m_chipselect}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_cs",    {31'd0, m_chipselect}, 32'd0);
    check("arst_wr_n",  {31'd0, m_write_n},    32'd1);
    check("arst_wdata", m_writedata,           32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    rd(4'd1, st); check("arst_period", st, 32'd0);
    rd(4'd2, st); check("arst_length", st, 32'd0);
    rd(4'd8, st); check("arst_tbl0", st, 32'd0);
    rd(4'd3, st); check("arst_status", st, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
